mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the CPU's instruction-fetch port and its load/store data port. The block serialises requests and drives the memory command, address and write data. It returns read data and a one-cycle ack to the winning requester, and raises a stall to the CPU while any request is outstanding. It sits between the fetch/memory stages and the memory block, and lets the core move from split memories to one shared memory.

Parameters:
W_CPU, 32, data and address width
MEM_LAT, 1, cycles from the issue cycle to valid mem_rdata. Legal range is 1 or more; 1 means mem_rdata is valid in the issue cycle itself.
STARVE_MAX, 3, maximum consecutive fetch losses before fetch is forced to win

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held high until if_ack
if_addr  in  W_CPU  fetch address; stable while if_req is high
if_rdata  out  W_CPU  fetched word; valid when if_ack is high, held until the next if_ack
if_ack  out  1  one-cycle completion pulse
d_req  in  1  data request; held high until d_ack
d_cmd  in  W_MEM_CMD  MEM_READ or MEM_WRITE
d_addr  in  W_CPU  data address
d_wdata  in  W_CPU  store data
d_rdata  out  W_CPU  load data; valid when d_ack is high, held until the next d_ack
d_ack  out  1  one-cycle completion pulse
mem_cmd  out  W_MEM_CMD  MEM_NOP, MEM_READ or MEM_WRITE
mem_addr  out  W_CPU  memory address
mem_wdata  out  W_CPU  memory write data
mem_rdata  in  W_CPU  memory read data
busy  out  1  high when state is not IDLE
stall  out  1  combinational: (if_req & ~if_ack) | (d_req & ~d_ack)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-low.
- Reset values while rst=0: state=IDLE, mem_cmd=MEM_NOP, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, starve_cnt=0, lat_cnt=0.
- Reset asserted mid-transaction: the in-flight access is abandoned and no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: evaluate requests at the clock edge.
  - A d_req with d_cmd=MEM_NOP counts as no request.
  - If any valid request is present: latch the winner, its address, its command and its write data, then go to ISSUE.
  - If no valid request is present, stay in IDLE.
- Priority: data wins over fetch, unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - starve_cnt increments when fetch loses while if_req is high.
  - starve_cnt clears when fetch is granted, or when if_req is low in IDLE.
  - starve_cnt saturates at STARVE_MAX.
- ISSUE: drive mem_cmd, mem_addr and mem_wdata from the latched values for exactly one cycle.
  - Write: go to RESP.
  - Read with MEM_LAT=1: capture mem_rdata at the end of the ISSUE cycle, then go to RESP.
  - Read with MEM_LAT>1: load lat_cnt=MEM_LAT-1, then go to WAIT.
- WAIT: mem_cmd=MEM_NOP. Decrement lat_cnt each cycle. In the cycle where lat_cnt==1, capture mem_rdata into the winner's rdata register, then go to RESP.
- RESP: pulse the winner's ack for one cycle, then go to IDLE. Requests are not evaluated in RESP, so a req still high during its ack cycle is not double-granted.
- Latency from the IDLE grant cycle t:
  - read ack in cycle t+MEM_LAT+1
  - write ack in cycle t+2
- Throughput is one access per MEM_LAT+2 cycles for reads and per 3 cycles for writes.
- Outside ISSUE, mem_cmd=MEM_NOP. mem_addr and mem_wdata hold their last values.
- The rdata register of the port that did not win is never modified.
- if_ack and d_ack are never high in the same cycle.
- Protocol violation (a requester changes addr or cmd while req is high): the latched values are used and the change is ignored.

Decomposition:
- Shared constants header (existing): W_CPU, W_MEM_CMD, MEM_NOP, MEM_READ, MEM_WRITE.
- Add to the same header: state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP, and grant encodings GNT_IF, GNT_D.
- One sub-module, arb_pick (combinational priority with the starvation override). Inputs: if_req, d_req_valid, starve_cnt. Output: the grant encoding.

Test Plan:
1. MEM_LAT=1, if_req=1 with if_addr=0x00400000, memory returns 0x2402000A:
   - mem_cmd=MEM_READ in cycle t+1
   - if_ack=1 with if_rdata=0x2402000A in cycle t+2
   - stall high during cycles t..t+1
2. MEM_LAT=3, d_req=1 with d_cmd=MEM_WRITE, d_addr=0x10010000, d_wdata=0xDEADBEEF:
   - mem_cmd=MEM_WRITE and mem_wdata=0xDEADBEEF for exactly one cycle
   - d_ack at t+2
   - d_req then re-issued as MEM_READ: d_rdata=0xDEADBEEF at t+4
3. Simultaneous if_req and d_req in IDLE: data is granted first. Fetch is granted in the next IDLE, and if_ack follows d_ack.
4. Fetch starvation: d_req continuously re-asserted after each ack while if_req is held. With STARVE_MAX=3, fetch is granted on the 4th decision.
5. rst=0 driven during WAIT:
   - next cycle: state=IDLE, mem_cmd=MEM_NOP, no ack pulse, if_rdata and d_rdata both 0
   - a new request after rst=1 completes normally
6. d_req=1 with d_cmd=MEM_NOP and if_req=0: stays IDLE, mem_cmd=MEM_NOP, busy=0, no ack, stall=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and encodings for the fetch/data memory port arbiter.
// Holds the memory command set, the arbiter state and grant encodings, and a command decode helper.
package mem_port_arbiter_pkg;

  localparam int W_CPU     = 32;
  localparam int W_MEM_CMD = 2;

  localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
  localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
  localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_gnt_e;

  // Only real accesses count as a data request; NOP and the unused code are ignored.
  function automatic logic cmd_is_access(input logic [W_MEM_CMD-1:0] cmd);
    return (cmd == MEM_READ) || (cmd == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection: data port wins unless fetch has lost STARVE_MAX
// decisions in a row while requesting.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int W_STARVE   = 2
) (
  input  logic                if_req,
  input  logic                d_req_valid,
  input  logic [W_STARVE-1:0] starve_cnt,
  output arb_gnt_e            gnt
);

  logic starved_s;

  // Priority decision with starvation override.
  always_comb begin
    starved_s = if_req && (starve_cnt == W_STARVE'(STARVE_MAX));
    if (d_req_valid && !starved_s) begin
      gnt = GNT_D;
    end else begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one single-ported memory,
// returning read data and a one-cycle ack to the winner and stalling the CPU meanwhile.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [W_CPU-1:0]     if_addr,
  output logic [W_CPU-1:0]     if_rdata,
  output logic                 if_ack,
  input  logic                 d_req,
  input  logic [W_MEM_CMD-1:0] d_cmd,
  input  logic [W_CPU-1:0]     d_addr,
  input  logic [W_CPU-1:0]     d_wdata,
  output logic [W_CPU-1:0]     d_rdata,
  output logic                 d_ack,
  output logic [W_MEM_CMD-1:0] mem_cmd,
  output logic [W_CPU-1:0]     mem_addr,
  output logic [W_CPU-1:0]     mem_wdata,
  input  logic [W_CPU-1:0]     mem_rdata,
  output logic                 busy,
  output logic                 stall
);

  localparam int W_STARVE = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int W_LAT    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam logic LAT_ONE = (MEM_LAT == 1);
  localparam logic [W_LAT-1:0] LAT_LOAD = W_LAT'(MEM_LAT - 1);
  localparam logic [W_STARVE-1:0] STARVE_TOP = W_STARVE'(STARVE_MAX);

  arb_state_e           state_q, state_d;
  arb_gnt_e             gnt_q, gnt_d;
  logic [W_MEM_CMD-1:0] cmd_q, cmd_d;
  logic [W_MEM_CMD-1:0] mem_cmd_q, mem_cmd_d;
  logic [W_CPU-1:0]     mem_addr_q, mem_addr_d;
  logic [W_CPU-1:0]     mem_wdata_q, mem_wdata_d;
  logic [W_CPU-1:0]     if_rdata_q, if_rdata_d;
  logic [W_CPU-1:0]     d_rdata_q, d_rdata_d;
  logic                 if_ack_q, if_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 busy_q, busy_d;
  logic [W_STARVE-1:0]  starve_cnt_q, starve_cnt_d;
  logic [W_LAT-1:0]     lat_cnt_q, lat_cnt_d;

  logic                 d_req_valid_s;
  logic                 any_req_s;
  logic                 capture_s;
  arb_gnt_e             pick_s;

  assign d_req_valid_s = d_req && cmd_is_access(d_cmd);
  assign any_req_s     = if_req || d_req_valid_s;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .W_STARVE   (W_STARVE)
  ) u_pick (
    .if_req      (if_req),
    .d_req_valid (d_req_valid_s),
    .starve_cnt  (starve_cnt_q),
    .gnt         (pick_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      gnt_q        <= GNT_IF;
      cmd_q        <= MEM_NOP;
      mem_cmd_q    <= MEM_NOP;
      mem_addr_q   <= {W_CPU{1'b0}};
      mem_wdata_q  <= {W_CPU{1'b0}};
      if_rdata_q   <= {W_CPU{1'b0}};
      d_rdata_q    <= {W_CPU{1'b0}};
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      starve_cnt_q <= {W_STARVE{1'b0}};
      lat_cnt_q    <= {W_LAT{1'b0}};
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req_s) begin
          state_d = ARB_ISSUE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if ((cmd_q == MEM_WRITE) || LAT_ONE) begin
          state_d = ARB_RESP;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (lat_cnt_q == W_LAT'(1)) begin
          state_d = ARB_RESP;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Grant latching, memory command drive, latency count, starvation count, read capture.
  always_comb begin
    gnt_d        = gnt_q;
    cmd_d        = cmd_q;
    mem_cmd_d    = MEM_NOP;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    capture_s    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // The memory command register is loaded here so it is valid throughout ISSUE.
        if (any_req_s) begin
          gnt_d = pick_s;
          if (pick_s == GNT_D) begin
            cmd_d       = d_cmd;
            mem_cmd_d   = d_cmd;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            cmd_d       = MEM_READ;
            mem_cmd_d   = MEM_READ;
            mem_addr_d  = if_addr;
            mem_wdata_d = mem_wdata_q;
          end
        end else begin
          gnt_d = gnt_q;
        end
        if (!if_req) begin
          starve_cnt_d = {W_STARVE{1'b0}};
        end else if (any_req_s && (pick_s == GNT_IF)) begin
          starve_cnt_d = {W_STARVE{1'b0}};
        end else if (any_req_s && (starve_cnt_q != STARVE_TOP)) begin
          starve_cnt_d = starve_cnt_q + W_STARVE'(1);
        end else begin
          starve_cnt_d = starve_cnt_q;
        end
      end
      ARB_ISSUE: begin
        if ((cmd_q == MEM_READ) && LAT_ONE) begin
          capture_s = 1'b1;
        end else if (cmd_q == MEM_READ) begin
          lat_cnt_d = LAT_LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q;
        end
      end
      ARB_WAIT: begin
        lat_cnt_d = lat_cnt_q - W_LAT'(1);
        if (lat_cnt_q == W_LAT'(1)) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      ARB_RESP: begin
        capture_s = 1'b0;
      end
      default: begin
        capture_s = 1'b0;
      end
    endcase
    if (capture_s) begin
      if (gnt_q == GNT_D) begin
        d_rdata_d = mem_rdata;
      end else begin
        if_rdata_d = mem_rdata;
      end
    end else begin
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
    end
  end

  // Registered handshake outputs, decoded from the upcoming state.
  always_comb begin
    busy_d = (state_d != ARB_IDLE);
    if (state_d == ARB_RESP) begin
      if_ack_d = (gnt_q == GNT_IF);
      d_ack_d  = (gnt_q == GNT_D);
    end else begin
      if_ack_d = 1'b0;
      d_ack_d  = 1'b0;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (prefix a_) and one
// with MEM_LAT=3 (prefix b_), each backed by a small behavioural memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic        a_if_req, a_if_ack, a_d_req, a_d_ack, a_busy, a_stall;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_d_cmd, a_mem_cmd;

  logic        b_if_req, b_if_ack, b_d_req, b_d_ack, b_busy, b_stall;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_d_cmd, b_mem_cmd;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .d_req(a_d_req), .d_cmd(a_d_cmd), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .mem_cmd(a_mem_cmd), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .stall(a_stall)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_cmd(b_d_cmd), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_cmd(b_mem_cmd), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .stall(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: read data valid in the issue cycle itself.
  function automatic logic [31:0] a_mem_word(input logic [31:0] addr);
    case (addr)
      32'h0040_0000: return 32'h2402_000A;
      32'h0040_0004: return 32'h8FA4_0000;
      default:       return 32'h0000_0000;
    endcase
  endfunction
  assign a_mem_rdata = a_mem_word(a_mem_addr);

  // Memory B: read data appears two cycles after the issue cycle.
  logic [31:0] b_mem [logic [31:0]];
  logic [31:0] b_pipe1, b_pipe2;
  always @(posedge clk) begin
    if (b_mem_cmd == MEM_READ && b_mem.exists(b_mem_addr)) b_pipe1 <= b_mem[b_mem_addr];
    else b_pipe1 <= 32'h0000_0000;
    b_pipe2 <= b_pipe1;
  end
  always @(posedge clk) begin
    if (b_mem_cmd == MEM_WRITE) b_mem[b_mem_addr] = b_mem_wdata;
  end
  assign b_mem_rdata = b_pipe2;

  task automatic test_reset();
    rst = 1'b0;
    a_if_req = 1'b1; a_if_addr = 32'h0040_0000;
    b_d_req = 1'b1;  b_d_cmd = MEM_WRITE; b_d_addr = 32'h1234_5678; b_d_wdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (a_mem_cmd !== MEM_NOP || a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0 ||
        a_if_ack !== 1'b0 || a_d_ack !== 1'b0 || a_if_rdata !== 32'h0 || a_d_rdata !== 32'h0 ||
        a_busy !== 1'b0 || a_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: cmd=%0d addr=%h wd=%h ack=%b/%b rd=%h/%h busy=%b stall=%b, required 0,0,0,0/0,0/0,busy 0,stall 1",
               a_mem_cmd, a_mem_addr, a_mem_wdata, a_if_ack, a_d_ack, a_if_rdata, a_d_rdata, a_busy, a_stall);
    end
    checks++;
    if (b_mem_cmd !== MEM_NOP || b_mem_addr !== 32'h0 || b_mem_wdata !== 32'h0 ||
        b_if_ack !== 1'b0 || b_d_ack !== 1'b0 || b_if_rdata !== 32'h0 || b_d_rdata !== 32'h0 ||
        b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: cmd=%0d addr=%h wd=%h ack=%b/%b rd=%h/%h busy=%b, required all zero",
               b_mem_cmd, b_mem_addr, b_mem_wdata, b_if_ack, b_d_ack, b_if_rdata, b_d_rdata, b_busy);
    end
    @(negedge clk);
    a_if_req = 1'b0; b_d_req = 1'b0; b_d_cmd = MEM_NOP;
    rst = 1'b1;
  endtask

  task automatic test_fetch_lat1();
    @(negedge clk);
    a_if_req = 1'b1; a_if_addr = 32'h0040_0000;
    #1;
    checks++;
    if (a_stall !== 1'b1 || a_if_ack !== 1'b0 || a_mem_cmd !== MEM_NOP) begin
      errors++;
      $display("FAIL fetch_t0: stall=%b ack=%b cmd=%0d, required 1 0 0", a_stall, a_if_ack, a_mem_cmd);
    end
    @(negedge clk); #1;
    checks++;
    if (a_mem_cmd !== MEM_READ || a_mem_addr !== 32'h0040_0000 || a_stall !== 1'b1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_t1: cmd=%0d addr=%h stall=%b busy=%b, required 1 00400000 1 1",
               a_mem_cmd, a_mem_addr, a_stall, a_busy);
    end
    @(negedge clk); #1;
    checks++;
    if (a_if_ack !== 1'b1 || a_if_rdata !== 32'h2402_000A || a_stall !== 1'b0 || a_d_ack !== 1'b0 ||
        a_mem_cmd !== MEM_NOP) begin
      errors++;
      $display("FAIL fetch_t2: if_ack=%b rdata=%h stall=%b d_ack=%b cmd=%0d, required 1 2402000a 0 0 0",
               a_if_ack, a_if_rdata, a_stall, a_d_ack, a_mem_cmd);
    end
    @(negedge clk);
    a_if_req = 1'b0;
    #1;
    checks++;
    if (a_if_ack !== 1'b0 || a_if_rdata !== 32'h2402_000A || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_t3: if_ack=%b rdata=%h busy=%b, required 0 2402000a 0", a_if_ack, a_if_rdata, a_busy);
    end
  endtask

  task automatic test_nop_request();
    int bad;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin a_d_req = 1'b1; a_d_cmd = MEM_NOP; a_d_addr = 32'h1001_0000; end
      #1;
      if (a_busy !== 1'b0 || a_mem_cmd !== MEM_NOP || a_d_ack !== 1'b0 || a_if_ack !== 1'b0 ||
          a_stall !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nop_req: %0d bad cycles (busy=%b cmd=%0d d_ack=%b stall=%b), required 0", bad,
               a_busy, a_mem_cmd, a_d_ack, a_stall);
    end
    @(negedge clk);
    a_d_req = 1'b0;
  endtask

  task automatic test_write_read_lat3();
    @(negedge clk);
    b_d_req = 1'b1; b_d_cmd = MEM_WRITE; b_d_addr = 32'h1001_0000; b_d_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (b_d_ack !== 1'b0 || b_stall !== 1'b1) begin
      errors++;
      $display("FAIL wr_t0: d_ack=%b stall=%b, required 0 1", b_d_ack, b_stall);
    end
    @(negedge clk); #1;
    checks++;
    if (b_mem_cmd !== MEM_WRITE || b_mem_wdata !== 32'hDEAD_BEEF || b_mem_addr !== 32'h1001_0000) begin
      errors++;
      $display("FAIL wr_t1: cmd=%0d wdata=%h addr=%h, required 2 deadbeef 10010000", b_mem_cmd, b_mem_wdata, b_mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (b_mem_cmd !== MEM_NOP || b_d_ack !== 1'b1 || b_if_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_t2: cmd=%0d d_ack=%b if_ack=%b, required 0 1 0", b_mem_cmd, b_d_ack, b_if_ack);
    end
    @(negedge clk);
    b_d_cmd = MEM_READ;
    #1;
    checks++;
    if (b_d_ack !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_t0: d_ack=%b busy=%b, required 0 0", b_d_ack, b_busy);
    end
    @(negedge clk); #1;
    checks++;
    if (b_mem_cmd !== MEM_READ || b_mem_addr !== 32'h1001_0000) begin
      errors++;
      $display("FAIL rd_t1: cmd=%0d addr=%h, required 1 10010000", b_mem_cmd, b_mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (b_mem_cmd !== MEM_NOP || b_d_ack !== 1'b0 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_t2: cmd=%0d d_ack=%b busy=%b, required 0 0 1", b_mem_cmd, b_d_ack, b_busy);
    end
    @(negedge clk); #1;
    checks++;
    if (b_d_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_t3: d_ack=%b, required 0", b_d_ack);
    end
    @(negedge clk); #1;
    checks++;
    if (b_d_ack !== 1'b1 || b_d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_t4: d_ack=%b d_rdata=%h, required 1 deadbeef", b_d_ack, b_d_rdata);
    end
    @(negedge clk);
    b_d_req = 1'b0; b_d_cmd = MEM_NOP;
    #1;
    checks++;
    if (b_d_ack !== 1'b0 || b_d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_t5: d_ack=%b d_rdata=%h, required 0 deadbeef", b_d_ack, b_d_rdata);
    end
  endtask

  task automatic test_data_priority();
    int d_at, i_at, both;
    d_at = -1; i_at = -1; both = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b_if_req = 1'b1; b_if_addr = 32'h0040_0100;
        b_d_req = 1'b1; b_d_cmd = MEM_READ; b_d_addr = 32'h1001_0000;
      end
      if (d_at >= 0) begin b_d_req = 1'b0; b_d_cmd = MEM_NOP; end
      if (i_at >= 0) b_if_req = 1'b0;
      #1;
      if (b_d_ack === 1'b1 && d_at < 0) d_at = k;
      if (b_if_ack === 1'b1 && i_at < 0) i_at = k;
      if (b_d_ack === 1'b1 && b_if_ack === 1'b1) both++;
    end
    checks++;
    if (d_at != 4 || i_at != 9) begin
      errors++;
      $display("FAIL prio_order: d_ack at %0d if_ack at %0d, required 4 and 9 (-1 = never)", d_at, i_at);
    end
    checks++;
    if (b_if_rdata !== 32'h1111_2222 || b_d_rdata !== 32'hDEAD_BEEF || both != 0) begin
      errors++;
      $display("FAIL prio_data: if_rdata=%h d_rdata=%h dual_acks=%0d, required 11112222 deadbeef 0",
               b_if_rdata, b_d_rdata, both);
    end
  endtask

  task automatic test_starvation();
    int n_d_before, i_at, d_after, both;
    n_d_before = 0; i_at = -1; d_after = -1; both = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b_if_req = 1'b1; b_if_addr = 32'h0040_0104;
        b_d_req = 1'b1; b_d_cmd = MEM_WRITE; b_d_addr = 32'h1001_0020; b_d_wdata = 32'h0BAD_F00D;
      end
      if (i_at >= 0) b_if_req = 1'b0;
      if (d_after >= 0) begin b_d_req = 1'b0; b_d_cmd = MEM_NOP; end
      #1;
      if (b_d_ack === 1'b1 && i_at < 0) n_d_before++;
      if (b_d_ack === 1'b1 && i_at >= 0 && d_after < 0) d_after = k;
      if (b_if_ack === 1'b1 && i_at < 0) i_at = k;
      if (b_d_ack === 1'b1 && b_if_ack === 1'b1) both++;
    end
    checks++;
    if (n_d_before != 3 || i_at != 13) begin
      errors++;
      $display("FAIL starve_grant: data wins before fetch=%0d if_ack at %0d, required 3 and 13", n_d_before, i_at);
    end
    checks++;
    if (d_after != 16 || both != 0) begin
      errors++;
      $display("FAIL starve_clear: next d_ack at %0d dual_acks=%0d, required 16 and 0", d_after, both);
    end
    checks++;
    if (b_if_rdata !== 32'h3333_4444 || b_d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL starve_data: if_rdata=%h d_rdata=%h, required 33334444 deadbeef", b_if_rdata, b_d_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    int acks, d_at;
    acks = 0; d_at = -1;
    @(negedge clk);
    b_d_req = 1'b1; b_d_cmd = MEM_READ; b_d_addr = 32'h1001_0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (b_busy !== 1'b1 || b_mem_cmd !== MEM_NOP || b_d_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstw_pre: busy=%b cmd=%0d d_ack=%b, required 1 0 0", b_busy, b_mem_cmd, b_d_ack);
    end
    rst = 1'b0; b_d_req = 1'b0; b_d_cmd = MEM_NOP;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_mem_cmd !== MEM_NOP || b_d_ack !== 1'b0 || b_if_ack !== 1'b0 ||
        b_if_rdata !== 32'h0 || b_d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstw_post: busy=%b cmd=%0d ack=%b/%b rd=%h/%h, required 0 0 0/0 0/0",
               b_busy, b_mem_cmd, b_if_ack, b_d_ack, b_if_rdata, b_d_rdata);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (b_d_ack === 1'b1 || b_if_ack === 1'b1 || b_busy === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL rstw_quiet: %0d cycles with ack/busy after reset, required 0", acks);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin b_d_req = 1'b1; b_d_cmd = MEM_READ; b_d_addr = 32'h1001_0000; end
      if (d_at >= 0) begin b_d_req = 1'b0; b_d_cmd = MEM_NOP; end
      #1;
      if (b_d_ack === 1'b1 && d_at < 0) d_at = k;
    end
    checks++;
    if (d_at != 4 || b_d_rdata !== 32'hDEAD_BEEF || b_if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstw_again: d_ack at %0d d_rdata=%h if_rdata=%h, required 4 deadbeef 0",
               d_at, b_d_rdata, b_if_rdata);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0;
    a_if_req = 1'b0; a_if_addr = 32'h0; a_d_req = 1'b0; a_d_cmd = MEM_NOP; a_d_addr = 32'h0; a_d_wdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_cmd = MEM_NOP; b_d_addr = 32'h0; b_d_wdata = 32'h0;
    b_mem[32'h0040_0100] = 32'h1111_2222;
    b_mem[32'h0040_0104] = 32'h3333_4444;
    test_reset();
    test_fetch_lat1();
    test_nop_request();
    test_write_read_lat3();
    test_data_priority();
    test_starvation();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
